// File: rtl/pc_gen_multi_pkg.sv
// Shared defaults and the per-cycle update rule encoding for the fetch-PC generator.
package pc_gen_multi_pkg;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_STEP      = 4;
  localparam int DEF_NUM_REDIR = 2;
  localparam int DEF_EPOCH_W   = 2;

  // Which update the PC state takes this cycle; earlier entries have priority.
  typedef enum logic [2:0] {
    RULE_HOLD,
    RULE_REDIR,
    RULE_REDIR_STALL,
    RULE_SEQ,
    RULE_IDLE
  } rule_e;

endpackage

// File: rtl/pc_gen_multi_arbiter.sv
// Fixed-priority redirect arbiter: the lowest set channel wins and its target is step-aligned.
module pc_gen_multi_arbiter
  import pc_gen_multi_pkg::*;
#(
  parameter int NUM_REDIR = DEF_NUM_REDIR,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int STEP      = DEF_STEP
) (
  input  logic [NUM_REDIR-1:0]        i_br,
  input  logic [NUM_REDIR*ADDR_W-1:0] i_br_addr,
  output logic                        o_new,
  output logic [ADDR_W-1:0]           o_naddr
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(STEP - 1));

  logic [ADDR_W-1:0] w_raw;

  // Scan from the highest index down so the lowest set channel is assigned last.
  always_comb begin
    w_raw = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (i_br[i]) w_raw = i_br_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign o_new   = |i_br;
  assign o_naddr = w_raw & ALIGN_MASK;

endmodule

// File: rtl/pc_gen_multi.sv
// Fetch-PC generator with prioritised redirects, a one-entry redirect buffer during holds,
// and an epoch tag on every issued fetch address.
module pc_gen_multi
  import pc_gen_multi_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                STEP      = DEF_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                NUM_REDIR = DEF_NUM_REDIR,
  parameter int                EPOCH_W   = DEF_EPOCH_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall0,
  input  logic                        stall2,
  input  logic [NUM_REDIR-1:0]        br,
  input  logic [NUM_REDIR*ADDR_W-1:0] br_addr,
  output logic                        sending,
  output logic [ADDR_W-1:0]           pc_o,
  output logic [EPOCH_W-1:0]          epoch_o,
  output logic                        pend_o
);

  localparam logic [ADDR_W-1:0] STEP1 = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] STEP2 = ADDR_W'(2 * STEP);

  logic [ADDR_W-1:0]  r_pc, r_pc_o, r_pend_addr;
  logic [EPOCH_W-1:0] r_epoch;
  logic               r_pend, r_sending;

  logic               w_new, w_eff;
  logic [ADDR_W-1:0]  w_naddr, w_eaddr;
  rule_e              w_rule;

  logic [ADDR_W-1:0]  w_pc_nxt, w_pc_o_nxt, w_pend_addr_nxt;
  logic [EPOCH_W-1:0] w_epoch_nxt;
  logic               w_pend_nxt, w_sending_nxt;

  pc_gen_multi_arbiter #(
    .NUM_REDIR (NUM_REDIR),
    .ADDR_W    (ADDR_W),
    .STEP      (STEP)
  ) u_arb (
    .i_br      (br),
    .i_br_addr (br_addr),
    .o_new     (w_new),
    .o_naddr   (w_naddr)
  );

  // A fresh request always supersedes the buffered one.
  assign w_eff   = w_new | r_pend;
  assign w_eaddr = w_new ? w_naddr : r_pend_addr;

  always_comb begin
    w_rule = RULE_IDLE;
    if (stall2)                w_rule = RULE_HOLD;
    else if (w_eff && !stall0) w_rule = RULE_REDIR;
    else if (w_eff)            w_rule = RULE_REDIR_STALL;
    else if (!stall0)          w_rule = RULE_SEQ;
  end

  always_comb begin
    w_pc_nxt        = r_pc;
    w_pc_o_nxt      = r_pc_o;
    w_epoch_nxt     = r_epoch;
    w_pend_nxt      = r_pend;
    w_pend_addr_nxt = r_pend_addr;
    w_sending_nxt   = 1'b0;
    case (w_rule)
      RULE_HOLD: begin
        if (w_eff) begin
          w_pend_nxt      = 1'b1;
          w_pend_addr_nxt = w_eaddr;
        end
      end
      // The redirecting stage fetches A itself, so IF resumes at A+STEP.
      RULE_REDIR: begin
        w_pc_o_nxt    = w_eaddr + STEP1;
        w_pc_nxt      = w_eaddr + STEP2;
        w_epoch_nxt   = r_epoch + EPOCH_W'(1);
        w_pend_nxt    = 1'b0;
        w_sending_nxt = 1'b1;
      end
      RULE_REDIR_STALL: begin
        w_pc_o_nxt    = w_eaddr;
        w_pc_nxt      = w_eaddr + STEP1;
        w_epoch_nxt   = r_epoch + EPOCH_W'(1);
        w_pend_nxt    = 1'b0;
        w_sending_nxt = 1'b1;
      end
      RULE_SEQ: begin
        w_pc_o_nxt    = r_pc;
        w_pc_nxt      = r_pc + STEP1;
        w_sending_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_pc_o      <= RESET_PC;
      r_epoch     <= '0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_sending   <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_pc_o      <= w_pc_o_nxt;
      r_epoch     <= w_epoch_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_sending   <= w_sending_nxt;
    end
  end

  assign pc_o    = r_pc_o;
  assign epoch_o = r_epoch;
  assign pend_o  = r_pend;
  assign sending = r_sending;

endmodule

// File: tb/tb_pc_gen_multi.sv
// Directed bench for pc_gen_multi: a default 32-bit instance and an 8-bit instance for wrap cases.
module tb_pc_gen_multi;

  logic        clock = 1'b0;
  logic        reset, stall0, stall2;
  logic [1:0]  br;
  logic [63:0] br_addr;
  logic        sending, pend_o;
  logic [31:0] pc_o;
  logic [1:0]  epoch_o;

  logic        reset8, stall0_8, stall2_8;
  logic [1:0]  br8;
  logic [15:0] br_addr8;
  logic        sending8, pend8;
  logic [7:0]  pc8;
  logic [1:0]  epoch8;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pc_gen_multi u_dut (
    .clock(clock), .reset(reset), .stall0(stall0), .stall2(stall2),
    .br(br), .br_addr(br_addr), .sending(sending), .pc_o(pc_o),
    .epoch_o(epoch_o), .pend_o(pend_o)
  );

  pc_gen_multi #(.ADDR_W(8), .STEP(4), .RESET_PC(8'h00), .NUM_REDIR(2), .EPOCH_W(2)) u_dut8 (
    .clock(clock), .reset(reset8), .stall0(stall0_8), .stall2(stall2_8),
    .br(br8), .br_addr(br_addr8), .sending(sending8), .pc_o(pc8),
    .epoch_o(epoch8), .pend_o(pend8)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [4];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    reset = 1'b1; stall0 = 1'b0; stall2 = 1'b0; br = '0; br_addr = '0;
    step(); step();
    checks++;
    if (pc_o !== 32'h0 || sending !== 1'b0 || epoch_o !== 2'd0 || pend_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pc=%h snd=%b ep=%0d pend=%b exp pc=0 snd=0 ep=0 pend=0",
               pc_o, sending, epoch_o, pend_o);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (pc_o !== exp_pc[i] || sending !== 1'b1 || epoch_o !== 2'd0) begin
        errors++;
        $display("FAIL free_run[%0d] pc=%h snd=%b ep=%0d exp pc=%h snd=1 ep=0",
                 i, pc_o, sending, epoch_o, exp_pc[i]);
      end
    end
  endtask

  task automatic test_redirect();
    br = 2'b01; br_addr = {32'h0, 32'h100};
    step();
    br = '0;
    checks++;
    if (pc_o !== 32'h104 || epoch_o !== 2'd1 || sending !== 1'b1) begin
      errors++;
      $display("FAIL redir pc=%h ep=%0d snd=%b exp pc=104 ep=1 snd=1", pc_o, epoch_o, sending);
    end
    step();
    checks++;
    if (pc_o !== 32'h108 || epoch_o !== 2'd1) begin
      errors++;
      $display("FAIL redir_next pc=%h ep=%0d exp pc=108 ep=1", pc_o, epoch_o);
    end
  endtask

  task automatic test_priority();
    br = 2'b11; br_addr = {32'h300, 32'h200};
    step();
    br = '0;
    checks++;
    if (pc_o !== 32'h204 || epoch_o !== 2'd2) begin
      errors++;
      $display("FAIL prio pc=%h ep=%0d exp pc=204 ep=2", pc_o, epoch_o);
    end
    step();
    checks++;
    if (pc_o !== 32'h208) begin
      errors++;
      $display("FAIL prio_next pc=%h exp pc=208", pc_o);
    end
  endtask

  task automatic test_hold_pending();
    stall2 = 1'b1; br = 2'b10; br_addr = {32'h41, 32'h0};
    for (int i = 0; i < 3; i++) begin
      step();
      br = '0;
      checks++;
      if (pend_o !== 1'b1 || pc_o !== 32'h208 || sending !== 1'b0 || epoch_o !== 2'd2) begin
        errors++;
        $display("FAIL hold[%0d] pend=%b pc=%h snd=%b ep=%0d exp pend=1 pc=208 snd=0 ep=2",
                 i, pend_o, pc_o, sending, epoch_o);
      end
    end
    stall2 = 1'b0; stall0 = 1'b1;
    step();
    checks++;
    if (pc_o !== 32'h40 || epoch_o !== 2'd3 || pend_o !== 1'b0 || sending !== 1'b1) begin
      errors++;
      $display("FAIL hold_release pc=%h ep=%0d pend=%b snd=%b exp pc=40 ep=3 pend=0 snd=1",
               pc_o, epoch_o, pend_o, sending);
    end
    step();
    checks++;
    if (pc_o !== 32'h40 || sending !== 1'b0 || epoch_o !== 2'd3) begin
      errors++;
      $display("FAIL stall0_idle pc=%h snd=%b ep=%0d exp pc=40 snd=0 ep=3", pc_o, sending, epoch_o);
    end
    stall0 = 1'b0;
  endtask

  task automatic test_supersede();
    stall2 = 1'b1; br = 2'b10; br_addr = {32'h40, 32'h0};
    step();
    checks++;
    if (pend_o !== 1'b1) begin
      errors++;
      $display("FAIL sup_pend pend=%b exp 1", pend_o);
    end
    stall2 = 1'b0; br = 2'b01; br_addr = {32'h0, 32'h80};
    step();
    br = '0;
    checks++;
    if (pc_o !== 32'h84 || epoch_o !== 2'd0 || pend_o !== 1'b0) begin
      errors++;
      $display("FAIL supersede pc=%h ep=%0d pend=%b exp pc=84 ep=0 pend=0", pc_o, epoch_o, pend_o);
    end
    step();
    checks++;
    if (pc_o !== 32'h88 || epoch_o !== 2'd0) begin
      errors++;
      $display("FAIL sup_next pc=%h ep=%0d exp pc=88 ep=0", pc_o, epoch_o);
    end
  endtask

  task automatic test_wrap_8bit();
    logic [7:0] exp_pc [3];
    logic [1:0] exp_ep [4];
    exp_pc = '{8'hF8, 8'hFC, 8'h00};
    exp_ep = '{2'd2, 2'd3, 2'd0, 2'd1};
    reset8 = 1'b1; stall0_8 = 1'b0; stall2_8 = 1'b0; br8 = '0; br_addr8 = '0;
    step();
    reset8 = 1'b0;
    br8 = 2'b01; br_addr8 = {8'h0, 8'hF6};
    for (int i = 0; i < 3; i++) begin
      step();
      br8 = '0;
      checks++;
      if (pc8 !== exp_pc[i] || epoch8 !== 2'd1) begin
        errors++;
        $display("FAIL wrap[%0d] pc=%h ep=%0d exp pc=%h ep=1", i, pc8, epoch8, exp_pc[i]);
      end
    end
    br8 = 2'b01; br_addr8 = {8'h0, 8'h10};
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (pc8 !== 8'h14 || epoch8 !== exp_ep[i]) begin
        errors++;
        $display("FAIL epoch_wrap[%0d] pc=%h ep=%0d exp pc=14 ep=%0d", i, pc8, epoch8, exp_ep[i]);
      end
    end
    stall2_8 = 1'b1; br_addr8 = {8'h0, 8'h20};
    step();
    br8 = '0;
    checks++;
    if (pend8 !== 1'b1 || pc8 !== 8'h14) begin
      errors++;
      $display("FAIL pend8 pend=%b pc=%h exp pend=1 pc=14", pend8, pc8);
    end
    reset8 = 1'b1;
    step();
    checks++;
    if (pend8 !== 1'b0 || pc8 !== 8'h00 || epoch8 !== 2'd0 || sending8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold pend=%b pc=%h ep=%0d snd=%b exp pend=0 pc=00 ep=0 snd=0",
               pend8, pc8, epoch8, sending8);
    end
    reset8 = 1'b0; stall2_8 = 1'b0; stall0_8 = 1'b1;
    step();
    checks++;
    if (pc8 !== 8'h00 || epoch8 !== 2'd0 || sending8 !== 1'b0) begin
      errors++;
      $display("FAIL after_reset pc=%h ep=%0d snd=%b exp pc=00 ep=0 snd=0", pc8, epoch8, sending8);
    end
  endtask

  initial begin
    reset8 = 1'b1; stall0_8 = 1'b0; stall2_8 = 1'b0; br8 = '0; br_addr8 = '0;
    test_reset();
    test_redirect();
    test_priority();
    test_hold_pending();
    test_supersede();
    test_wrap_8bit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
